pipeline_0_fetch: RTL and testbench

Instruction-fetch stage of the Kaiserlake pipeline, directly upstream of the decoder and `pipeline_1_readreg`. It owns the program counter, issues reads to a synchronous instruction memory with one-cycle latency, and presents one instruction per cycle with its PC and a valid flag. It absorbs downstream stalls through a one-entry hold buffer, takes branch redirects with a wrong-path flush, and supports halt.

---
 rtl/pipeline_0_fetch.sv | 150 +++++++++++++++
 tb/tb_pipeline_0_fetch.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_0_fetch.sv
// Purpose      : instruction-fetch stage; owns the PC, reads a 1-cycle sync imem, presents instr/pc/valid.
// Latency      : 1 cycle from read issue to presentation; one instruction per cycle while update=1.
// Backpressure : update=0 parks the presented word in a one-entry hold buffer and stops issuing reads.
//
// Ports:
//   clk, rst          clock and async active-low reset
//   update            downstream accepts the presented instruction this cycle
//   branch_taken/_target  redirect request and address (wins over everything)
//   halt_req          stop fetching until the next redirect
//   mem_addr/mem_rd   read request to instruction memory; mem_rdata returns next cycle
//   instr_out/pc_out/valid_out  presented slot (zeros when not valid)
//   halted            stage is in HALT
module pipeline_0_fetch #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            update,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            halt_req,
  input  logic [15:0]     mem_rdata,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_rd,
  output logic [15:0]     instr_out,
  output logic [PC_W-1:0] pc_out,
  output logic            valid_out,
  output logic            halted
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t          state_q,       state_d;
  logic [PC_W-1:0] fetch_pc_q,    fetch_pc_d;
  logic            inflight_q,    inflight_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
  logic            hold_vld_q,    hold_vld_d;
  logic [15:0]     hold_instr_q,  hold_instr_d;
  logic [PC_W-1:0] hold_pc_q,     hold_pc_d;

  logic            slot_vld;
  logic [15:0]     slot_instr;
  logic [PC_W-1:0] slot_pc;
  logic            pres_vld;
  logic            rd_c;
  logic [PC_W-1:0] addr_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      hold_vld_q    <= 1'b0;
      hold_instr_q  <= '0;
      hold_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      hold_vld_q    <= hold_vld_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    hold_vld_d    = hold_vld_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    rd_c          = 1'b0;
    addr_c        = fetch_pc_q;

    // The hold buffer always takes precedence: it holds the older word.
    slot_vld   = 1'b0;
    slot_instr = '0;
    slot_pc    = '0;
    if (hold_vld_q) begin
      slot_vld   = 1'b1;
      slot_instr = hold_instr_q;
      slot_pc    = hold_pc_q;
    end else if (inflight_q) begin
      slot_vld   = 1'b1;
      slot_instr = mem_rdata;
      slot_pc    = inflight_pc_q;
    end

    // A redirect turns the current slot into wrong-path, so it is never presented.
    pres_vld = slot_vld && !branch_taken && (state_q == ST_RUN);

    if (branch_taken) begin
      hold_vld_d    = 1'b0;
      rd_c          = 1'b1;
      addr_c        = branch_target;
      inflight_d    = 1'b1;
      inflight_pc_d = branch_target;
      fetch_pc_d    = branch_target + PC_ONE;
      state_d       = ST_RUN;
    end else if (state_q == ST_HALT) begin
      inflight_d = 1'b0;
      hold_vld_d = 1'b0;
    end else begin
      // Issue whenever the slot will be free next cycle: either consumed now or empty.
      if (update || !pres_vld) begin
        rd_c          = 1'b1;
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + PC_ONE;
      end else begin
        inflight_d = 1'b0;
      end

      // Memory data is only valid for one cycle, so a stalled word must be parked.
      if (!update && !hold_vld_q && inflight_q) begin
        hold_vld_d   = 1'b1;
        hold_instr_d = mem_rdata;
        hold_pc_d    = inflight_pc_q;
      end

      if (update && hold_vld_q) begin
        hold_vld_d = 1'b0;
      end

      // Whatever is presented this cycle is still accepted if update=1; nothing else survives.
      if (halt_req) begin
        state_d    = ST_HALT;
        inflight_d = 1'b0;
        hold_vld_d = 1'b0;
      end
    end
  end

  // Outputs are gated by rst so they read as idle the instant reset is asserted,
  // independent of what the inputs are doing during reset.
  assign mem_rd    = rst && rd_c;
  assign mem_addr  = addr_c;
  assign valid_out = rst && pres_vld;
  assign instr_out = valid_out ? slot_instr : 16'h0000;
  assign pc_out    = valid_out ? slot_pc : '0;
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_pipeline_0_fetch.sv
module tb_pipeline_0_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        update = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic        halt_req = 1'b0;

  logic [15:0] rdata_a, rdata_b;
  logic [7:0]  mem_addr_a, mem_addr_b, pc_out_a, pc_out_b;
  logic        mem_rd_a, mem_rd_b, valid_a, valid_b, halted_a, halted_b;
  logic [15:0] instr_a, instr_b;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return 16'h1000 + {8'h00, a};
  endfunction

  // Synchronous instruction memories; garbage on the bus when no read was issued.
  always @(posedge clk) rdata_a <= mem_rd_a ? mem_word(mem_addr_a) : 16'($urandom);
  always @(posedge clk) rdata_b <= mem_rd_b ? mem_word(mem_addr_b) : 16'($urandom);

  pipeline_0_fetch #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .update(update), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt_req(halt_req), .mem_rdata(rdata_a),
    .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .instr_out(instr_a),
    .pc_out(pc_out_a), .valid_out(valid_a), .halted(halted_a)
  );

  pipeline_0_fetch #(.PC_W(8), .RESET_PC(8'hFE)) dut_fe (
    .clk(clk), .rst(rst), .update(update), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt_req(halt_req), .mem_rdata(rdata_b),
    .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .instr_out(instr_b),
    .pc_out(pc_out_b), .valid_out(valid_b), .halted(halted_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: the stage is viewed as "at most one pending instruction
  // (pc) plus the next fetch address", with no notion of hold vs in-flight.
  bit         m_pend = 1'b0;
  bit         m_halt = 1'b0;
  logic [7:0] m_pc   = 8'h00;
  logic [7:0] m_next = 8'h00;

  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst) begin
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd_a), 32'd0);
        chk("rst_instr", 32'(instr_a), 32'd0);
        chk("rst_pc", 32'(pc_out_a), 32'd0);
        chk("rst_halted", 32'(halted_a), 32'd0);
        m_pend = 1'b0;
        m_halt = 1'b0;
        m_next = 8'h00;
      end else begin
        bit         e_vld, e_rd, mask_rd;
        logic [7:0] e_addr;
        e_vld   = m_pend && !branch_taken && !m_halt;
        mask_rd = !branch_taken && !m_halt && halt_req;
        if (branch_taken) begin
          e_rd = 1'b1; e_addr = branch_target;
        end else if (m_halt) begin
          e_rd = 1'b0; e_addr = m_next;
        end else begin
          e_rd = update || !e_vld; e_addr = m_next;
        end
        chk("valid_out", 32'(valid_a), 32'(e_vld));
        chk("instr_out", 32'(instr_a), e_vld ? 32'(mem_word(m_pc)) : 32'd0);
        chk("pc_out", 32'(pc_out_a), e_vld ? 32'(m_pc) : 32'd0);
        chk("halted", 32'(halted_a), 32'(m_halt));
        if (!mask_rd) begin
          chk("mem_rd", 32'(mem_rd_a), 32'(e_rd));
          if (e_rd) chk("mem_addr", 32'(mem_addr_a), 32'(e_addr));
        end
        if (branch_taken) begin
          m_pend = 1'b1; m_pc = branch_target; m_next = branch_target + 8'd1; m_halt = 1'b0;
        end else if (m_halt) begin
          m_pend = 1'b0;
        end else if (halt_req) begin
          m_halt = 1'b1; m_pend = 1'b0;
        end else if (update || !e_vld) begin
          m_pend = 1'b1; m_pc = m_next; m_next = m_next + 8'd1;
        end
      end
    end
  end

  task automatic drive(input bit u, input bit b, input logic [7:0] t, input bit h);
    @(posedge clk);
    #1;
    update = u; branch_taken = b; branch_target = t; halt_req = h;
  endtask

  initial begin
    chk_en = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("init_mem_rd", 32'(mem_rd_a), 32'd0);
    chk("init_valid", 32'(valid_a), 32'd0);
    chk("init_halted", 32'(halted_a), 32'd0);
    update = 1'b1;
    repeat (3) @(posedge clk);

    // c0: first cycle after release
    @(posedge clk); #1; rst = 1'b1; update = 1'b1;
    #5;
    chk("c0_valid", 32'(valid_a), 32'd0);
    chk("c0_rd", 32'(mem_rd_a), 32'd1);
    chk("c0_addr", 32'(mem_addr_a), 32'h00);
    chk("fe_c0_addr", 32'(mem_addr_b), 32'hFE);
    drive(1, 0, 8'h00, 0); #5;
    chk("c1_instr", 32'(instr_a), 32'h1000);
    chk("c1_pc", 32'(pc_out_a), 32'h00);
    chk("fe_c1_addr", 32'(mem_addr_b), 32'hFF);
    chk("fe_c1_pc", 32'(pc_out_b), 32'hFE);
    drive(1, 0, 8'h00, 0); #5;
    chk("c2_instr", 32'(instr_a), 32'h1001);
    chk("fe_c2_addr", 32'(mem_addr_b), 32'h00);
    chk("fe_c2_pc", 32'(pc_out_b), 32'hFF);
    // Stall for 3 cycles while pc 2 is presented
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 8'h00, 0); #5;
      chk("stall_instr", 32'(instr_a), 32'h1002);
      chk("stall_rd", 32'(mem_rd_a), 32'd0);
      if (i == 0) chk("fe_c3_pc", 32'(pc_out_b), 32'h00);
    end
    drive(1, 0, 8'h00, 0); #5;
    chk("rel_instr", 32'(instr_a), 32'h1002);
    chk("rel_addr", 32'(mem_addr_a), 32'h03);
    chk("fe_rel_addr", 32'(mem_addr_b), 32'h01);
    drive(1, 0, 8'h00, 0); #5;
    chk("rel_next_pc", 32'(pc_out_a), 32'h03);
    chk("rel_next_vld", 32'(valid_a), 32'd1);
    chk("fe_wrap_pc", 32'(pc_out_b), 32'h01);
    // Branch during a stall
    drive(0, 0, 8'h00, 0);
    drive(0, 1, 8'h40, 0); #5;
    chk("br_valid", 32'(valid_a), 32'd0);
    chk("br_addr", 32'(mem_addr_a), 32'h40);
    drive(1, 0, 8'h00, 0); #5;
    chk("br_tgt_pc", 32'(pc_out_a), 32'h40);
    chk("br_tgt_instr", 32'(instr_a), 32'h1040);
    drive(1, 0, 8'h00, 0); #5;
    chk("br_next_pc", 32'(pc_out_a), 32'h41);
    // Halt
    drive(1, 0, 8'h00, 1); #5;
    chk("halt_req_vld", 32'(valid_a), 32'd1);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 8'h00, 0); #5;
      chk("halt_halted", 32'(halted_a), 32'd1);
      chk("halt_rd", 32'(mem_rd_a), 32'd0);
      chk("halt_vld", 32'(valid_a), 32'd0);
    end
    drive(1, 1, 8'h10, 0); #5;
    chk("unhalt_addr", 32'(mem_addr_a), 32'h10);
    drive(1, 0, 8'h00, 0); #5;
    chk("unhalt_halted", 32'(halted_a), 32'd0);
    chk("unhalt_pc", 32'(pc_out_a), 32'h10);
    // Async reset mid-stall
    drive(0, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);
    @(posedge clk); #3; rst = 1'b0; #1;
    chk("arst_rd", 32'(mem_rd_a), 32'd0);
    chk("arst_vld", 32'(valid_a), 32'd0);
    chk("arst_instr", 32'(instr_a), 32'd0);
    chk("arst_pc", 32'(pc_out_a), 32'd0);
    chk("arst_halted", 32'(halted_a), 32'd0);
    repeat (2) @(posedge clk);
    @(posedge clk); #1; rst = 1'b1; update = 1'b1;
    #5;
    chk("rerun_vld", 32'(valid_a), 32'd0);
    chk("rerun_addr", 32'(mem_addr_a), 32'h00);
    chk("rerun_rd", 32'(mem_rd_a), 32'd1);
    drive(1, 0, 8'h00, 0); #5;
    chk("rerun_instr", 32'(instr_a), 32'h1000);

    // Randomised traffic, checked only by the model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0,
            8'($urandom), $urandom_range(0, 39) == 0);
    end
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
